// File: rtl/hexstr2digest.sv
// hexstr2digest: packs a typed hex ASCII string into a digest, validates the
// entry (length, legal characters, Enter, Backspace), then compares the
// assembled digest against a reference digest once that becomes valid.
module hexstr2digest #(
    parameter int unsigned NIBBLES      = 32,
    parameter bit          LSN_FIRST    = 1'b1,
    parameter bit          ACCEPT_UPPER = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [7:0]             ascii,
    input  logic                   clear,
    input  logic                   ref_valid,
    input  logic [4*NIBBLES-1:0]   ref_digest,
    output logic [4*NIBBLES-1:0]   digest,
    output logic [5:0]             nib_count,
    output logic                   ready,
    output logic                   done,
    output logic                   match,
    output logic                   err,
    output logic [1:0]             err_code
);

    localparam int unsigned W        = 4 * NIBBLES;
    localparam logic [5:0]  FULL_CNT = 6'(NIBBLES);
    localparam logic [7:0]  CH_BS    = 8'h08;
    localparam logic [7:0]  CH_CR    = 8'h0d;
    localparam logic [1:0]  E_SHORT  = 2'b01;
    localparam logic [1:0]  E_OVER   = 2'b10;
    localparam logic [1:0]  E_ILLEG  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WAIT_REF,
        S_RESULT,
        S_ERR
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] digest_q, digest_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         match_q, match_d;
    logic [1:0]   code_q, code_d;

    logic [4:0]   dec;
    logic         accept;
    int unsigned  wr_pos;
    int unsigned  bs_pos;

    // Returns {legal, nibble} for one ASCII character.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, c[3:0]};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, c[3:0] + 4'd9};
        if (ACCEPT_UPPER && c >= 8'h41 && c <= 8'h46) return {1'b1, c[3:0] + 4'd9};
        return 5'b0_0000;
    endfunction

    // Maps the p-th received nibble onto its slot inside the digest.
    function automatic int unsigned nib_pos(input logic [5:0] p);
        if (LSN_FIRST) return 32'(p);
        return NIBBLES - 1 - 32'(p);
    endfunction

    // Next-state, nibble write and comparison logic.
    always_comb begin
        state_d  = state_q;
        digest_d = digest_q;
        cnt_d    = cnt_q;
        match_d  = match_q;
        code_d   = code_q;

        dec    = hex_decode(ascii);
        accept = en && (ascii != 8'h00) &&
                 (state_q == S_IDLE || state_q == S_COLLECT);
        wr_pos = nib_pos(cnt_q);
        bs_pos = nib_pos(cnt_q - 6'd1);

        if (clear) begin
            state_d  = S_IDLE;
            digest_d = '0;
            cnt_d    = '0;
            match_d  = 1'b0;
            code_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (dec[4]) begin
                            for (int unsigned n = 0; n < NIBBLES; n++)
                                if (n == wr_pos) digest_d[4*n +: 4] = dec[3:0];
                            cnt_d   = 6'd1;
                            state_d = S_COLLECT;
                        end else if (ascii != CH_BS && ascii != CH_CR) begin
                            code_d  = E_ILLEG;
                            state_d = S_ERR;
                        end
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        if (dec[4]) begin
                            if (cnt_q == FULL_CNT) begin
                                code_d  = E_OVER;
                                state_d = S_ERR;
                            end else begin
                                for (int unsigned n = 0; n < NIBBLES; n++)
                                    if (n == wr_pos) digest_d[4*n +: 4] = dec[3:0];
                                cnt_d = cnt_q + 6'd1;
                            end
                        end else if (ascii == CH_BS) begin
                            for (int unsigned n = 0; n < NIBBLES; n++)
                                if (n == bs_pos) digest_d[4*n +: 4] = 4'h0;
                            cnt_d = cnt_q - 6'd1;
                            if (cnt_q == 6'd1) state_d = S_IDLE;
                        end else if (ascii == CH_CR) begin
                            if (cnt_q == FULL_CNT) begin
                                state_d = S_WAIT_REF;
                            end else begin
                                code_d  = E_SHORT;
                                state_d = S_ERR;
                            end
                        end else begin
                            code_d  = E_ILLEG;
                            state_d = S_ERR;
                        end
                    end
                end
                S_WAIT_REF: begin
                    if (ref_valid) begin
                        match_d = (digest_q == ref_digest);
                        state_d = S_RESULT;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            digest_q <= '0;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            digest_q <= digest_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            code_q   <= code_d;
        end
    end

    assign digest    = digest_q;
    assign nib_count = cnt_q;
    assign ready     = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign done      = (state_q == S_RESULT);
    assign match     = match_q;
    assign err       = (state_q == S_ERR);
    assign err_code  = (state_q == S_ERR) ? code_q : 2'b00;

endmodule

// File: tb/tb_hexstr2digest.sv
// Testbench for hexstr2digest: table of entry strings with expected final
// state, a result scoreboard for done/match/latency, and hand sequences for
// clear priority, lower-case-only decoding, MSN-first order, async reset
// and null characters.
module tb_hexstr2digest;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [7:0]   ascii;
    logic         clear;
    logic         ref_valid;
    logic [127:0] ref_digest;

    logic [127:0] digest;
    logic [5:0]   nib_count;
    logic         ready, done, match, err;
    logic [1:0]   err_code;

    logic [127:0] lc_digest;
    logic [5:0]   lc_nib_count;
    logic         lc_ready, lc_done, lc_match, lc_err;
    logic [1:0]   lc_err_code;

    logic [127:0] ms_digest;
    logic [5:0]   ms_nib_count;
    logic         ms_ready, ms_done, ms_match, ms_err;
    logic [1:0]   ms_err_code;

    always #5 clk = ~clk;

    hexstr2digest dut (
        .clk(clk), .reset(rst_n), .en(en), .ascii(ascii), .clear(clear),
        .ref_valid(ref_valid), .ref_digest(ref_digest),
        .digest(digest), .nib_count(nib_count), .ready(ready), .done(done),
        .match(match), .err(err), .err_code(err_code)
    );

    hexstr2digest #(.ACCEPT_UPPER(1'b0)) dut_lc (
        .clk(clk), .reset(rst_n), .en(en), .ascii(ascii), .clear(clear),
        .ref_valid(ref_valid), .ref_digest(ref_digest),
        .digest(lc_digest), .nib_count(lc_nib_count), .ready(lc_ready), .done(lc_done),
        .match(lc_match), .err(lc_err), .err_code(lc_err_code)
    );

    hexstr2digest #(.LSN_FIRST(1'b0)) dut_ms (
        .clk(clk), .reset(rst_n), .en(en), .ascii(ascii), .clear(clear),
        .ref_valid(ref_valid), .ref_digest(ref_digest),
        .digest(ms_digest), .nib_count(ms_nib_count), .ready(ms_ready), .done(ms_done),
        .match(ms_match), .err(ms_err), .err_code(ms_err_code)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result scoreboard: pushed when a full-length Enter is driven,
    // popped when done rises.
    typedef struct {
        string name;
        logic  match;
        int    lat;
    } res_t;

    res_t sb[$];
    int   cyc = 0;
    int   enter_cyc = 0;
    logic prev_done = 1'b0;
    res_t r;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                r = sb.pop_front();
                chk({r.name, "_match"}, 128'(match), 128'(r.match));
                chk({r.name, "_latency"}, 128'(cyc - enter_cyc), 128'(r.lat));
            end
        end
        prev_done = done;
    end

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        en    = 1'b1;
        ascii = c;
        @(posedge clk);
        #1;
        if (c == 8'h0d) enter_cyc = cyc;
        en    = 1'b0;
        ascii = 8'h00;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    function automatic logic [7:0] map_char(input byte b);
        if (b == ".") return 8'h0d;
        if (b == "<") return 8'h08;
        return 8'(b);
    endfunction

    typedef struct {
        string        name;
        string        chars;
        int           ref_delay;   // -1: ref_valid stays low
        logic [127:0] refd;
        logic         exp_done;
        logic         exp_match;
        logic         exp_err;
        logic [1:0]   exp_code;
        logic [5:0]   exp_cnt;
        logic [127:0] exp_dig;
        logic         exp_rdy;
    } vec_t;

    localparam int NV = 10;
    localparam logic [127:0] FULL  = 128'hFEDCBA9876543210FEDCBA9876543210;
    localparam logic [127:0] SHORT = 128'h0EDCBA9876543210FEDCBA9876543210;

    vec_t  tbl[NV];
    vec_t  v;
    string s32;
    string s31;
    logic [7:0] c;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        s32 = "0123456789abcdef0123456789ABCDEF";
        s31 = s32.substr(0, 30);
        tbl[0] = '{"full_match", {s32, "."}, 0, FULL, 1'b1, 1'b1, 1'b0, 2'b00, 6'd32, FULL, 1'b0};
        tbl[1] = '{"mismatch", {s32, "."}, 5, FULL ^ 128'h1, 1'b1, 1'b0, 1'b0, 2'b00, 6'd32, FULL, 1'b0};
        tbl[2] = '{"backspace", "12<3", -1, '0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd2, 128'h31, 1'b1};
        tbl[3] = '{"idle_bs_cr", "<.<", -1, '0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0, '0, 1'b1};
        tbl[4] = '{"short", {s31, "."}, -1, '0, 1'b0, 1'b0, 1'b1, 2'b01, 6'd31, SHORT, 1'b0};
        tbl[5] = '{"overflow", {s32, "7"}, -1, '0, 1'b0, 1'b0, 1'b1, 2'b10, 6'd32, FULL, 1'b0};
        tbl[6] = '{"illegal_g", "12g", -1, '0, 1'b0, 1'b0, 1'b1, 2'b11, 6'd2, 128'h21, 1'b0};
        tbl[7] = '{"illegal_idle", "z", -1, '0, 1'b0, 1'b0, 1'b1, 2'b11, 6'd0, '0, 1'b0};
        tbl[8] = '{"bs_to_idle", "5<7", -1, '0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd1, 128'h7, 1'b1};
        tbl[9] = '{"err_sticky", "g12.", -1, '0, 1'b0, 1'b0, 1'b1, 2'b11, 6'd0, '0, 1'b0};

        rst_n      = 1'b0;
        en         = 1'b0;
        ascii      = 8'h00;
        clear      = 1'b0;
        ref_valid  = 1'b0;
        ref_digest = '0;

        #3;
        chk("reset_digest", digest, '0);
        chk("reset_cnt", 128'(nib_count), 128'd0);
        chk("reset_ready", 128'(ready), 128'd1);
        chk("reset_done_match", 128'({done, match}), 128'd0);
        chk("reset_err", 128'({err, err_code}), 128'd0);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            ref_digest = v.refd;
            ref_valid  = (v.ref_delay == 0);
            do_clear();
            for (int k = 0; k < v.chars.len(); k++) begin
                c = map_char(v.chars[k]);
                if (c == 8'h0d && v.exp_done)
                    sb.push_back('{v.name, v.exp_match, v.ref_delay + 1});
                send(c);
            end
            if (v.ref_delay > 0) begin
                for (int d = 0; d < v.ref_delay; d++) begin
                    @(posedge clk);
                    #2;
                    chk({v.name, "_wait_done"}, 128'(done), 128'd0);
                end
                @(negedge clk);
                ref_valid = 1'b1;
            end
            for (int k = 0; k < 10 && sb.size() > 0; k++) begin
                @(posedge clk);
                #2;
            end
            if (sb.size() > 0) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got done=0 expected done=1 within 10 cycles", v.name);
                sb.delete();
            end
            chk({v.name, "_digest"}, digest, v.exp_dig);
            chk({v.name, "_cnt"}, 128'(nib_count), 128'(v.exp_cnt));
            chk({v.name, "_ready"}, 128'(ready), 128'(v.exp_rdy));
            chk({v.name, "_done"}, 128'(done), 128'(v.exp_done));
            chk({v.name, "_match"}, 128'(match), 128'(v.exp_match));
            chk({v.name, "_err"}, 128'(err), 128'(v.exp_err));
            chk({v.name, "_code"}, 128'(err_code), 128'(v.exp_code));
            ref_valid = 1'b0;
        end

        // Clear wins over a simultaneous character.
        do_clear();
        send("1");
        send("2");
        @(negedge clk);
        clear = 1'b1;
        en    = 1'b1;
        ascii = "5";
        @(posedge clk);
        #1;
        clear = 1'b0;
        en    = 1'b0;
        ascii = 8'h00;
        chk("clear_prio_cnt", 128'(nib_count), 128'd0);
        chk("clear_prio_digest", digest, '0);
        chk("clear_prio_ready", 128'(ready), 128'd1);

        // Upper-case rejection and MSN-first packing.
        do_clear();
        send("1");
        send("A");
        chk("lc_upper_err", 128'({lc_err, lc_err_code}), 128'(3'b111));
        chk("lc_upper_digest", lc_digest, 128'h1);
        chk("uc_upper_digest", digest, 128'hA1);
        chk("ms_digest", ms_digest, 128'h1A00_0000_0000_0000_0000_0000_0000_0000);
        chk("ms_cnt", 128'(ms_nib_count), 128'd2);

        // Null characters never change state.
        do_clear();
        send(8'h00);
        chk("null_idle", 128'({ready, err, nib_count}), 128'({1'b1, 1'b0, 6'd0}));
        send("1");
        send("2");
        for (int k = 0; k < 3; k++) send(8'h00);
        chk("null_collect_cnt", 128'(nib_count), 128'd2);
        chk("null_collect_digest", digest, 128'h21);

        // Asynchronous reset between clock edges.
        send("a");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", 128'(nib_count), 128'd0);
        chk("async_rst_digest", digest, '0);
        chk("async_rst_ready", 128'(ready), 128'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cnt", 128'(nib_count), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hexstr2digest.md
Name: hexstr2digest

Overview:
- Decoder counterpart of the digest-to-ASCII emitter. It accepts a stream of hexadecimal ASCII characters, for example an expected MD5 digest typed on the keyboard, and packs them into a 128-bit digest.
- Validates the string: length, legal characters, Enter to terminate, Backspace to edit.
- Once terminated, waits for the hardware-computed digest and reports match or mismatch.
- Sits on the same char strobe / ascii bus as the string-capture logic, running on the keyboard-rate clock.

Parameters:
- NIBBLES, 32: number of hex characters that make one complete digest. Digest width is 4*NIBBLES.
- LSN_FIRST, 1: 1 = the k-th accepted char fills digest[4k+3:4k], the same nibble order the digest emitter produces; 0 = the first char fills the most-significant nibble.
- ACCEPT_UPPER, 1: 1 = 'A'-'F' are accepted as hex; 0 = only 'a'-'f' are accepted.

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  character strobe; the char on ascii is presented this cycle.
- ascii  in  8  ASCII code; 8'h00 is a null and is always ignored.
- clear  in  1  synchronous restart to IDLE; has priority over en.
- ref_valid  in  1  level; ref_digest is stable and valid.
- ref_digest  in  4*NIBBLES  computed digest to compare against.
- digest  out  4*NIBBLES  assembled digest.
- nib_count  out  6  number of nibbles currently held.
- ready  out  1  1 in IDLE or COLLECT (characters are accepted).
- done  out  1  level; comparison finished.
- match  out  1  level; valid when done=1.
- err  out  1  level; entry aborted.
- err_code  out  2  reason for the abort: 01 = short, 10 = overflow, 11 = illegal char. It is 00 when err=0.

Behaviour:
- Reset (async, reset=0): state IDLE, digest=0, nib_count=0, ready=1, done=0, match=0, err=0, err_code=00.
- A character is accepted when en=1, ascii!=8'h00, state is IDLE or COLLECT, and clear=0. One character per cycle; all updates are registered on the accepting edge.
- State IDLE (nib_count=0):
  - Hex char: write its nibble, nib_count=1, go to COLLECT.
  - 8'h08 (Backspace) and 8'h0d (Enter): ignored.
  - Any other char: go to ERR with code 11.
- State COLLECT:
  - Hex char with nib_count<NIBBLES: write the nibble at position nib_count, then nib_count+1.
  - Hex char with nib_count==NIBBLES: go to ERR with code 10. digest is retained.
  - 8'h08: nib_count-1 and the vacated nibble is zeroed. If the result is 0, go to IDLE.
  - 8'h0d with nib_count==NIBBLES: go to WAIT_REF.
  - 8'h0d with nib_count<NIBBLES: go to ERR with code 01.
  - Any other char: go to ERR with code 11.
- Hex decode:
  - '0'-'9' (30-39) map to 0-9.
  - 'a'-'f' (61-66) map to 10-15.
  - 'A'-'F' (41-46) map to 10-15 only when ACCEPT_UPPER=1; otherwise they are illegal.
- Nibble position for the p-th nibble (0-based):
  - LSN_FIRST=1: bits [4p+3:4p].
  - LSN_FIRST=0: bits [4(NIBBLES-1-p)+3 -: 4].
- State WAIT_REF:
  - ready=0; en is ignored.
  - On the first edge where ref_valid=1: match=(digest==ref_digest), done=1, go to RESULT.
  - Latency: if ref_valid is already high, done rises exactly one clock after the Enter-accepting edge.
- State RESULT: done, match and digest are held; en is ignored until clear.
- State ERR: err=1, err_code is held, ready=0, en is ignored until clear.
- clear=1 (any state): on the next edge go to IDLE with all registers at their reset values, except that the async reset path is not used. Any simultaneous en is discarded.
- Reset mid-entry: immediately returns to reset values; no partial result survives.
- nib_count never exceeds NIBBLES and never goes below 0.
- digest is combinationally equal to its register; no bits are driven beyond 4*NIBBLES.

Test Plan:
- Full string, LSN_FIRST=1: feed "0123456789abcdef0123456789ABCDEF", then 8'h0d, with ref_valid=1 and ref_digest=128'hFEDCBA9876543210FEDCBA9876543210.
  Required: nib_count reaches 32, and done=1 and match=1 one clock after Enter.
- Mismatch and latency: same string, ref_valid held low for 5 cycles after Enter, with ref_digest differing in bit 0.
  Required: done stays 0 while waiting, then done=1 and match=0 one clock after ref_valid rises.
- Backspace: feed "12", 8'h08, "3".
  Required: digest[7:0]=8'h31 and nib_count=2. Also, Backspace in IDLE leaves nib_count=0 and does not set err.
- Errors:
  - 31 hex chars then Enter gives err=1, err_code=01.
  - 33 hex chars gives err_code=10 on the 33rd char.
  - 'g' (8'h67) gives err_code=11.
  - With ACCEPT_UPPER=0, 'A' gives err_code=11.
- Clear priority: assert clear together with en='5' while in COLLECT.
  Required: next cycle state is IDLE, nib_count=0, digest=0.
- Async reset: pull reset low mid-string, between clock edges.
  Required: outputs are at reset values before the next clk edge; null chars (8'h00) with en=1 never change state.
